// File: rtl/cdb_arbiter_if.sv
// Result-writeback bus between the two producers, the CDB arbiter and the reorder buffer.
// Producers assert xValid with index/value for one cycle per result and must stop once xFull is seen
// (one slot of slack covers a one-cycle-late reaction); the CDB side has no ready, cdbValid marks each result once.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 aluValid;
  logic [ROB_WIDTH-1:0] aluRobIndex;
  logic [31:0]          aluValue;
  logic                 aluFull;
  logic                 lsbValid;
  logic [ROB_WIDTH-1:0] lsbRobIndex;
  logic [31:0]          lsbValue;
  logic                 lsbFull;
  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbRobIndex;
  logic [31:0]          cdbValue;
  logic                 cdbSrc;
  logic                 dropError;

  modport master (
    output aluValid, aluRobIndex, aluValue, lsbValid, lsbRobIndex, lsbValue,
    input  aluFull, lsbFull, cdbValid, cdbRobIndex, cdbValue, cdbSrc, dropError
  );

  modport slave (
    input  aluValid, aluRobIndex, aluValue, lsbValid, lsbRobIndex, lsbValue,
    output aluFull, lsbFull, cdbValid, cdbRobIndex, cdbValue, cdbSrc, dropError
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two per-source result FIFOs (0 = ALU, 1 = LSB) feeding a registered common data bus
// through a round-robin arbiter; clearIn flushes everything in flight.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_WIDTH = 2,
  localparam int FIFO_DEPTH = 2 ** FIFO_WIDTH
) (
  input  logic          clockIn,
  input  logic          resetIn,
  input  logic          clearIn,
  cdb_arbiter_if.slave  bus
);
  localparam int ENTRY_WIDTH = ROB_WIDTH + 32;
  localparam logic [FIFO_WIDTH:0]   CNT_FULL   = (FIFO_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_ALMOST = (FIFO_WIDTH + 1)'(FIFO_DEPTH - 1);
  localparam logic [FIFO_WIDTH:0]   CNT_ONE    = (FIFO_WIDTH + 1)'(1);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE    = FIFO_WIDTH'(1);

  typedef logic [ENTRY_WIDTH-1:0] entry_t;

  entry_t                fifoMem [2][FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] head    [2];
  logic [FIFO_WIDTH-1:0] tail    [2];
  logic [FIFO_WIDTH:0]   count   [2];
  logic                  lastGrant;

  logic                  pushReq  [2];
  entry_t                pushData [2];
  logic                  nonEmpty [2];
  logic                  doPush   [2];
  logic                  doPop    [2];
  logic                  grantValid;
  logic                  grantSrc;

  logic                  cdbValidQ;
  logic [ROB_WIDTH-1:0]  cdbRobIndexQ;
  logic [31:0]           cdbValueQ;
  logic                  cdbSrcQ;
  logic                  dropErrorQ;

  // Arbitration looks only at registered FIFO state, so a fresh push is never bypassed onto the CDB.
  always_comb begin
    pushReq[0]  = bus.aluValid;
    pushData[0] = {bus.aluRobIndex, bus.aluValue};
    pushReq[1]  = bus.lsbValid;
    pushData[1] = {bus.lsbRobIndex, bus.lsbValue};
    for (int i = 0; i < 2; i++) begin
      nonEmpty[i] = (count[i] != '0);
      doPush[i]   = pushReq[i] && (count[i] < CNT_FULL);
    end
    grantValid = nonEmpty[0] || nonEmpty[1];
    grantSrc   = 1'b0;
    if (nonEmpty[0] && nonEmpty[1]) grantSrc = ~lastGrant;
    else if (nonEmpty[1])           grantSrc = 1'b1;
    doPop[0] = grantValid && !grantSrc;
    doPop[1] = grantValid && grantSrc;
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      for (int i = 0; i < 2; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      cdbValidQ    <= 1'b0;
      cdbRobIndexQ <= '0;
      cdbValueQ    <= '0;
      cdbSrcQ      <= 1'b0;
      lastGrant    <= 1'b1;
      dropErrorQ   <= 1'b0;
    end else if (clearIn) begin
      for (int i = 0; i < 2; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      cdbValidQ <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (doPush[i]) begin
          fifoMem[i][tail[i]] <= pushData[i];
          tail[i]             <= tail[i] + PTR_ONE;
        end
        if (doPop[i]) head[i] <= head[i] + PTR_ONE;
        case ({doPush[i], doPop[i]})
          2'b10:   count[i] <= count[i] + CNT_ONE;
          2'b01:   count[i] <= count[i] - CNT_ONE;
          default: count[i] <= count[i];
        endcase
        if (pushReq[i] && !doPush[i]) dropErrorQ <= 1'b1;
      end
      cdbValidQ <= grantValid;
      if (grantValid) begin
        {cdbRobIndexQ, cdbValueQ} <= fifoMem[grantSrc][head[grantSrc]];
        cdbSrcQ                   <= grantSrc;
        lastGrant                 <= grantSrc;
      end
    end
  end

  assign bus.aluFull     = (count[0] >= CNT_ALMOST);
  assign bus.lsbFull     = (count[1] >= CNT_ALMOST);
  assign bus.cdbValid    = cdbValidQ;
  assign bus.cdbRobIndex = cdbRobIndexQ;
  assign bus.cdbValue    = cdbValueQ;
  assign bus.cdbSrc      = cdbSrcQ;
  assign bus.dropError   = dropErrorQ;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random stimulus for cdb_arbiter, checked against a queue-based model of the
// writeback rules plus fixed expectations from the directed scenarios.
module tb_cdb_arbiter;
  logic clk;
  logic rst;
  logic clr;

  cdb_arbiter_if #(.ROB_WIDTH(4)) bus ();

  cdb_arbiter #(.ROB_WIDTH(4), .FIFO_WIDTH(2)) dut (
    .clockIn (clk),
    .resetIn (rst),
    .clearIn (clr),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: one queue of {index,value} per source.
  logic [35:0] alu_q[$];
  logic [35:0] lsb_q[$];
  logic        m_valid, m_src, m_last, m_drop;
  logic [3:0]  m_idx;
  logic [31:0] m_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic av, input logic [35:0] ae, input logic lv,
                            input logic [35:0] le, input logic c, input logic r);
    int          na;
    int          nl;
    logic        g;
    logic [35:0] e;
    na = alu_q.size();
    nl = lsb_q.size();
    if (r) begin
      alu_q.delete(); lsb_q.delete();
      m_valid = 0; m_idx = 0; m_val = 0; m_src = 0; m_last = 1; m_drop = 0;
    end else if (c) begin
      alu_q.delete(); lsb_q.delete();
      m_valid = 0; m_last = 1;
    end else begin
      m_valid = (na > 0) || (nl > 0);
      if (na > 0 && nl > 0) g = !m_last;
      else                  g = (nl > 0);
      if (m_valid) begin
        e = g ? lsb_q.pop_front() : alu_q.pop_front();
        m_idx = e[35:32]; m_val = e[31:0]; m_src = g; m_last = g;
      end
      if (av) begin
        if (na < 4) alu_q.push_back(ae); else m_drop = 1;
      end
      if (lv) begin
        if (nl < 4) lsb_q.push_back(le); else m_drop = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("cdbValid",    32'(bus.cdbValid),    32'(m_valid));
    chk("cdbRobIndex", 32'(bus.cdbRobIndex), 32'(m_idx));
    chk("cdbValue",    bus.cdbValue,         m_val);
    chk("cdbSrc",      32'(bus.cdbSrc),      32'(m_src));
    chk("aluFull",     32'(bus.aluFull),     32'(alu_q.size() >= 3));
    chk("lsbFull",     32'(bus.lsbFull),     32'(lsb_q.size() >= 3));
    chk("dropError",   32'(bus.dropError),   32'(m_drop));
  endtask

  task automatic tick(input logic av, input logic [3:0] ai, input logic [31:0] avl,
                      input logic lv, input logic [3:0] li, input logic [31:0] lvl,
                      input logic c, input logic r);
    bus.aluValid = av; bus.aluRobIndex = ai; bus.aluValue = avl;
    bus.lsbValid = lv; bus.lsbRobIndex = li; bus.lsbValue = lvl;
    clr = c; rst = r;
    @(posedge clk);
    model_step(av, {ai, avl}, lv, {li, lvl}, c, r);
    #1;
    check_all();
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bus.aluValid = 0; bus.aluRobIndex = 0; bus.aluValue = 0;
    bus.lsbValid = 0; bus.lsbRobIndex = 0; bus.lsbValue = 0;
    rst = 1; clr = 0;
    do_reset();
    do_reset();
    chk("rst_valid", 32'(bus.cdbValid), 0);
    chk("rst_drop",  32'(bus.dropError), 0);

    // Single ALU result: two-edge latency, one valid cycle.
    tick(1, 3, 32'h11, 0, 0, 0, 0, 0);
    chk("t1_early", 32'(bus.cdbValid), 0);
    idle();
    chk("t1_valid", 32'(bus.cdbValid), 1);
    chk("t1_idx",   32'(bus.cdbRobIndex), 3);
    chk("t1_val",   bus.cdbValue, 32'h11);
    chk("t1_src",   32'(bus.cdbSrc), 0);
    idle();
    chk("t1_once",  32'(bus.cdbValid), 0);

    // Simultaneous ALU and LSB after reset: ALU wins the tie.
    do_reset();
    tick(1, 1, 32'hA, 1, 2, 32'hB, 0, 0);
    idle();
    chk("t2_idx0", 32'(bus.cdbRobIndex), 1);
    chk("t2_src0", 32'(bus.cdbSrc), 0);
    idle();
    chk("t2_idx1", 32'(bus.cdbRobIndex), 2);
    chk("t2_src1", 32'(bus.cdbSrc), 1);
    idle();
    chk("t2_end",  32'(bus.cdbValid), 0);

    // Both sources stream with full-flag backpressure: grants alternate.
    for (int k = 0; k < 8; k++) begin
      tick(1'(alu_q.size() < 3), 4'(k), 32'h1000 + 32'(k),
           1'(lsb_q.size() < 3), 4'(k + 8), 32'h2000 + 32'(k), 0, 0);
      if (k >= 1) begin
        chk("t3_valid", 32'(bus.cdbValid), 1);
        chk("t3_src",   32'(bus.cdbSrc), 32'((k - 1) & 1));
      end
    end
    for (int k = 0; k < 6; k++) idle();

    // Overfill: both push every cycle, ignoring full flags.
    do_reset();
    for (int k = 0; k < 8; k++)
      tick(1, 4'(k), 32'h3000 + 32'(k), 1, 4'(k), 32'h4000 + 32'(k), 0, 0);
    chk("t4_drop", 32'(bus.dropError), 1);
    for (int k = 0; k < 10; k++) idle();
    chk("t4_sticky", 32'(bus.dropError), 1);

    // Clear with three entries held per source.
    do_reset();
    for (int k = 0; k < 5; k++)
      tick(1, 4'(k), 32'h5000 + 32'(k), 1, 4'(k + 5), 32'h6000 + 32'(k), 0, 0);
    chk("t5_afull", 32'(bus.aluFull), 1);
    chk("t5_lfull", 32'(bus.lsbFull), 1);
    tick(1, 4'hF, 32'hDEAD, 0, 0, 0, 1, 0);
    chk("t5_valid", 32'(bus.cdbValid), 0);
    chk("t5_afull0", 32'(bus.aluFull), 0);
    chk("t5_lfull0", 32'(bus.lsbFull), 0);
    tick(1, 4'hC, 32'h77, 1, 4'hD, 32'h88, 0, 0);
    idle();
    chk("t5_new_idx", 32'(bus.cdbRobIndex), 32'hC);
    chk("t5_new_src", 32'(bus.cdbSrc), 0);
    idle();
    chk("t5_new_lsb", 32'(bus.cdbValue), 32'h88);
    idle();

    // ALU stream wraps the pointers, then reset mid-stream.
    for (int k = 0; k < 10; k++) begin
      tick(1, 4'(k), 32'h100 + 32'(k), 0, 0, 0, 0, 1'(k == 6));
      if (k == 6) begin
        chk("t6_valid", 32'(bus.cdbValid), 0);
        chk("t6_idx",   32'(bus.cdbRobIndex), 0);
        chk("t6_val",   bus.cdbValue, 0);
      end
    end
    for (int k = 0; k < 4; k++) idle();

    // Random traffic with occasional clear and reset.
    for (int k = 0; k < 400; k++)
      tick(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
    for (int k = 0; k < 10; k++) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
